if_fetch_unit: RTL

- Instruction-fetch initiator: generates PC, drives `ce` and `addr` of the instruction ROM, captures the combinational ROM read data into the IF/ID pipeline register.
- Sits between the pipeline control unit (stall/flush), the ID stage (branch redirect with one delay slot) and the instruction ROM.
- Detects misaligned and out-of-range fetch addresses and halts fetching until an exception flush redirects it.

---
 rtl/cpu_defs_pkg.sv | 7 +
 rtl/if_fetch_unit_next_pc.sv | 23 ++
 rtl/if_fetch_unit.sv | 134 +++++++++++++
 3 files changed

// File: rtl/cpu_defs_pkg.sv
// cpu_defs: shared fetch-stage state encodings and defaults.
package cpu_defs;
    typedef enum logic [1:0] {BOOT, RUN, HOLD, HALT} fetch_state_e;
    localparam logic [31:0] INST_NOP     = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam int          ROM_AW_DEF   = 17;
endpackage

// File: rtl/if_fetch_unit_next_pc.sv
// if_next_pc: next-pc priority mux (flush > stall > pending > branch > +4) and fetch fault check.
module if_next_pc
    import cpu_defs::*;
#(
    parameter int ROM_AW = ROM_AW_DEF
) (
    input  logic [31:0] pc_i,
    input  logic        flush_i,
    input  logic [31:0] flush_pc_i,
    input  logic        stall_i,
    input  logic        pend_vld_i,
    input  logic [31:0] pend_tgt_i,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_target_i,
    output logic [31:0] next_pc_o,
    output logic        fault_o
);
    assign next_pc_o = flush_i       ? flush_pc_i      :
                       stall_i       ? pc_i            :
                       pend_vld_i    ? pend_tgt_i      :
                       branch_flag_i ? branch_target_i : pc_i + 32'd4;
    assign fault_o = (pc_i[1:0] != 2'b00) || ((pc_i >> (ROM_AW + 2)) != 32'd0);
endmodule

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: PC generation, ROM fetch and IF/ID register with fault halt.
// Define IF_PERF_CNT_EN to add fetch/stall performance counters.
module if_fetch_unit
    import cpu_defs::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter int          ROM_AW   = ROM_AW_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_target_i,
    output logic        rom_ce,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_inst_i,
    output logic [31:0] id_pc_o,
    output logic [31:0] id_inst_o,
    output logic        id_valid_o,
    output logic        fetch_err_o,
    output logic [31:0] fetch_bad_addr_o
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetch_cnt_o,
    output logic [31:0] perf_stall_cnt_o
`endif
);
    fetch_state_e state_q, state_d;
    logic [31:0] pc_q, pc_d, id_pc_q, id_pc_d, id_inst_q, id_inst_d;
    logic [31:0] bad_q, bad_d, pend_tgt_q, pend_tgt_d, next_pc;
    logic        id_valid_q, id_valid_d, err_q, err_d, pend_vld_q, pend_vld_d;
    logic        active, fault, load;

    if_next_pc #(.ROM_AW(ROM_AW)) u_next_pc (
        .pc_i(pc_q), .flush_i(flush), .flush_pc_i(flush_pc), .stall_i(stall),
        .pend_vld_i(pend_vld_q), .pend_tgt_i(pend_tgt_q),
        .branch_flag_i(branch_flag_i), .branch_target_i(branch_target_i),
        .next_pc_o(next_pc), .fault_o(fault)
    );

    assign active = (state_q == RUN) || (state_q == HOLD);
    assign load   = !flush && active && !fault && !stall;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        id_pc_d    = id_pc_q;
        id_inst_d  = id_inst_q;
        id_valid_d = id_valid_q;
        err_d      = err_q;
        bad_d      = bad_q;
        pend_vld_d = pend_vld_q;
        pend_tgt_d = pend_tgt_q;
        if (flush) begin
            state_d    = RUN;
            pc_d       = next_pc;
            id_inst_d  = INST_NOP;
            id_valid_d = 1'b0;
            err_d      = 1'b0;
            pend_vld_d = 1'b0;
        end else if (state_q == BOOT) begin
            state_d = RUN;
        end else if (active && fault) begin
            // faulting address is never presented to the ROM; a bubble replaces it
            state_d    = HALT;
            err_d      = 1'b1;
            bad_d      = pc_q;
            id_inst_d  = INST_NOP;
            id_valid_d = 1'b0;
        end else if (active) begin
            state_d = stall ? HOLD : RUN;
            pc_d    = next_pc;
            if (stall && branch_flag_i) begin
                pend_vld_d = 1'b1;
                pend_tgt_d = branch_target_i;
            end
            if (!stall) begin
                id_pc_d    = pc_q;
                id_inst_d  = rom_inst_i;
                id_valid_d = 1'b1;
                pend_vld_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= BOOT;
            pc_q       <= RESET_PC;
            id_pc_q    <= 32'd0;
            id_inst_q  <= INST_NOP;
            id_valid_q <= 1'b0;
            err_q      <= 1'b0;
            bad_q      <= 32'd0;
            pend_vld_q <= 1'b0;
            pend_tgt_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            id_pc_q    <= id_pc_d;
            id_inst_q  <= id_inst_d;
            id_valid_q <= id_valid_d;
            err_q      <= err_d;
            bad_q      <= bad_d;
            pend_vld_q <= pend_vld_d;
            pend_tgt_q <= pend_tgt_d;
        end
    end

`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, stall_cnt_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_cnt_q <= 32'd0;
            stall_cnt_q <= 32'd0;
        end else begin
            fetch_cnt_q <= fetch_cnt_q + {31'd0, load};
            stall_cnt_q <= stall_cnt_q + {31'd0, state_q == HOLD};
        end
    end
    assign perf_fetch_cnt_o = fetch_cnt_q;
    assign perf_stall_cnt_o = stall_cnt_q;
`endif

    assign rom_ce           = active && !fault;
    assign rom_addr         = pc_q;
    assign id_pc_o          = id_pc_q;
    assign id_inst_o        = id_inst_q;
    assign id_valid_o       = id_valid_q;
    assign fetch_err_o      = err_q;
    assign fetch_bad_addr_o = bad_q;
endmodule
